// File: rtl/nerv_dmem_bridge_pkg.sv
// -----------------------------------------------------------------------------
// nerv_dmem_pkg
// Shared types and constants for the NERV data-memory bridge.
//   state_t                 : bridge FSM state encoding
//   TIMEOUT_CYCLES_DEFAULT  : default watchdog limit in clock cycles
// -----------------------------------------------------------------------------
package nerv_dmem_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE,
        ST_BUBBLE
    } state_t;

endpackage

// File: rtl/nerv_dmem_bridge_if.sv
// -----------------------------------------------------------------------------
// nerv_dmem_bridge_if
// Request/response bus between the data-memory bridge and the memory system.
//   bus_req_valid/ready          : request handshake (bridge -> memory)
//   bus_req_addr/wstrb/wdata     : request fields, wstrb == 0 means read
//   bus_rsp_valid                : one-cycle response or write acknowledge
//   bus_rsp_rdata, bus_rsp_err   : response data and error, qualified by valid
// Modports: master = bridge side, slave = memory side.
// -----------------------------------------------------------------------------
interface nerv_dmem_bridge_if;

    logic        bus_req_valid;
    logic        bus_req_ready;
    logic [31:0] bus_req_addr;
    logic [3:0]  bus_req_wstrb;
    logic [31:0] bus_req_wdata;
    logic        bus_rsp_valid;
    logic [31:0] bus_rsp_rdata;
    logic        bus_rsp_err;

    modport master (
        output bus_req_valid, bus_req_addr, bus_req_wstrb, bus_req_wdata,
        input  bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

    modport slave (
        input  bus_req_valid, bus_req_addr, bus_req_wstrb, bus_req_wdata,
        output bus_req_ready, bus_rsp_valid, bus_rsp_rdata, bus_rsp_err
    );

endinterface

// File: rtl/nerv_dmem_bridge_watchdog.sv
// -----------------------------------------------------------------------------
// nerv_dmem_watchdog
// Cycle counter that flags an outstanding bus transaction as timed out.
//   clock, reset : clock and synchronous active-high reset
//   clear        : restart the count (asserted when a request is captured)
//   count_en     : a transaction is outstanding this cycle
//   expired      : this is the TIMEOUT_CYCLES-th outstanding cycle
// Only instantiated when NERV_DMEM_BRIDGE_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module nerv_dmem_watchdog
    import nerv_dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int unsigned    CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // count holds the number of outstanding cycles already elapsed, so the
    // limit is reached during the cycle where count equals TIMEOUT_CYCLES-1.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = count_en && (count == LAST);

endmodule

// File: rtl/nerv_dmem_bridge.sv
// -----------------------------------------------------------------------------
// nerv_dmem_bridge
// Bridges the NERV core's combinational data-memory port onto a registered
// valid/ready request bus with a one-cycle response, stalling the core until
// the response arrives. After commit a one-cycle bubble lets the core reissue.
//   clock, reset        : clock and synchronous active-high reset
//   stall_in            : stall requested by other sources
//   stall               : stall to core (stall_in OR internal stall)
//   dmem_valid/addr/wstrb/wdata : core request (wstrb == 0 means read)
//   dmem_rdata          : read data to core, held in a register
//   bus_error           : sticky bus error / timeout flag
//   bus                 : nerv_dmem_bridge_if.master request/response bus
// Optional feature: define NERV_DMEM_BRIDGE_TIMEOUT_EN to add a watchdog that
// completes a transaction with an error after TIMEOUT_CYCLES cycles.
// -----------------------------------------------------------------------------
module nerv_dmem_bridge
    import nerv_dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    output logic        stall,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        bus_error,
    nerv_dmem_bridge_if.master bus
);

    // The watchdog compares against TIMEOUT_CYCLES-1, so it needs at least 2.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
        $error("nerv_dmem_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state;
    state_t      state_next;
    logic        int_stall;
    logic        capture;
    logic        outstanding;
    logic        rsp_accept;
    logic        timeout_hit;
    logic        req_is_read;

    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic [31:0] rdata_q;

    assign capture     = (state == ST_IDLE) && dmem_valid;
    assign outstanding = (state == ST_REQ) || (state == ST_WAIT);
    // Responses are only taken in WAIT; one arriving alongside ready is dropped.
    assign rsp_accept  = (state == ST_WAIT) && bus.bus_rsp_valid;
    assign req_is_read = (req_wstrb == 4'b0000);

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    nerv_dmem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .clear    (capture),
        .count_en (outstanding),
        .expired  (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // ---------------------------------------------------------------- state register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------- next state
    // NOTE: a default is assigned before the case so no path leaves
    // state_next unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:   if (dmem_valid) state_next = ST_REQ;
            ST_REQ:    begin
                // The watchdog wins over a coincident ready: the transaction
                // is abandoned and any late response is dropped outside WAIT.
                if (timeout_hit)             state_next = ST_DONE;
                else if (bus.bus_req_ready)  state_next = ST_WAIT;
            end
            ST_WAIT:   if (bus.bus_rsp_valid || timeout_hit) state_next = ST_DONE;
            ST_DONE:   if (!stall_in) state_next = ST_BUBBLE;
            // The core reissues during the bubble; its dmem_valid is ignored here.
            ST_BUBBLE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        int_stall         = 1'b0;
        bus.bus_req_valid = 1'b0;
        unique case (state)
            ST_IDLE:   int_stall = dmem_valid;
            ST_REQ:    begin
                int_stall         = 1'b1;
                bus.bus_req_valid = 1'b1;
            end
            ST_WAIT:   int_stall = 1'b1;
            default:   int_stall = 1'b0;
        endcase
    end

    assign stall             = stall_in | int_stall;
    assign bus.bus_req_addr  = req_addr;
    assign bus.bus_req_wstrb = req_wstrb;
    assign bus.bus_req_wdata = req_wdata;
    assign dmem_rdata        = rdata_q;

    // ---------------------------------------------------------------- request capture
    // NOTE: the captured request fields carry no reset; they are only observed
    // while bus_req_valid is high, which always follows a capture.
    always_ff @(posedge clock) begin
        if (capture) begin
            req_addr  <= dmem_addr;
            req_wstrb <= dmem_wstrb;
            req_wdata <= dmem_wdata;
        end
    end

    // ---------------------------------------------------------------- response / error
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q   <= '0;
            bus_error <= 1'b0;
        end else if (rsp_accept) begin
            if (bus.bus_rsp_err) begin
                bus_error <= 1'b1;
            end
            // Write acknowledges leave the read-data register untouched.
            if (req_is_read) begin
                rdata_q <= bus.bus_rsp_err ? 32'h0 : bus.bus_rsp_rdata;
            end
        end else if (timeout_hit) begin
            bus_error <= 1'b1;
            rdata_q   <= '0;
        end
    end

endmodule

// File: tb/tb_nerv_dmem_bridge.sv
// -----------------------------------------------------------------------------
// tb_nerv_dmem_bridge
// Transaction-level bench for nerv_dmem_bridge. Each transaction is scheduled
// as phases (gap, capture, request, wait, done, bubble) whose lengths the bench
// chooses; the expected outputs of every cycle follow directly from that
// schedule and are queued for a single compare process on the falling edge.
// -----------------------------------------------------------------------------
module tb_nerv_dmem_bridge;

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    localparam int unsigned TO   = 8;
    localparam int          DMAX = 2;
`else
    localparam int unsigned TO   = 256;
    localparam int          DMAX = 5;
`endif

    localparam int PH_IDLE = 0, PH_REQ = 1, PH_WAIT = 2, PH_DONE = 3, PH_BUBBLE = 4;

    logic        clock;
    logic        reset;
    logic        stall_in;
    logic        stall;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        bus_error;

    nerv_dmem_bridge_if bus_if ();

    nerv_dmem_bridge #(
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall_in   (stall_in),
        .stall      (stall),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .bus_error  (bus_error),
        .bus        (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------- scoreboard
    typedef struct {
        logic        stall;
        logic        brv;
        logic [31:0] rdata;
        logic        err;
        bit          fields;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the core must currently see.
    logic [31:0] m_rdata;
    logic        m_err;

    // Request currently being presented on the bus.
    logic [31:0] t_addr;
    logic [3:0]  t_wstrb;
    logic [31:0] t_wdata;

    bit quiet;

    // Per-transaction tallies read from the DUT, pinned by literal checks.
    int          cnt_stall, cnt_req, cnt_done, cnt_done_stall, unstable;
    logic [31:0] done_rdata, bubble_rdata, req_addr_seen;
    logic [31:0] first_addr, first_wdata;
    logic [3:0]  first_wstrb;
    bit          first_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("stall", {31'd0, stall}, {31'd0, e.stall});
            check("bus_req_valid", {31'd0, bus_if.bus_req_valid}, {31'd0, e.brv});
            check("dmem_rdata", dmem_rdata, e.rdata);
            check("bus_error", {31'd0, bus_error}, {31'd0, e.err});
            if (e.fields) begin
                check("bus_req_addr", bus_if.bus_req_addr, e.addr);
                check("bus_req_wstrb", {28'd0, bus_if.bus_req_wstrb}, {28'd0, e.wstrb});
                check("bus_req_wdata", bus_if.bus_req_wdata, e.wdata);
            end
        end
    end

    function automatic logic rnd_bit();
        return quiet ? 1'b0 : 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] rnd32();
        return 32'($urandom);
    endfunction

    // One clock cycle: queue the expected outputs for the inputs just driven,
    // tally DUT observations at the falling edge, then step past the next edge.
    task automatic tick(input logic int_stall, input logic brv, input int phase);
        exp_t e;
        e.stall  = stall_in | int_stall;
        e.brv    = brv;
        e.rdata  = m_rdata;
        e.err    = m_err;
        e.fields = brv;
        e.addr   = t_addr;
        e.wstrb  = t_wstrb;
        e.wdata  = t_wdata;
        exp_q.push_back(e);
        @(negedge clock);
        if (stall) cnt_stall++;
        if (phase == PH_REQ) begin
            if (bus_if.bus_req_valid) cnt_req++;
            req_addr_seen = bus_if.bus_req_addr;
            if (first_req) begin
                first_req   = 1'b0;
                first_addr  = bus_if.bus_req_addr;
                first_wstrb = bus_if.bus_req_wstrb;
                first_wdata = bus_if.bus_req_wdata;
            end else if (bus_if.bus_req_addr !== first_addr || bus_if.bus_req_wstrb !== first_wstrb ||
                         bus_if.bus_req_wdata !== first_wdata) begin
                unstable++;
            end
        end
        if (phase == PH_DONE) begin
            cnt_done++;
            if (stall) cnt_done_stall++;
            done_rdata = dmem_rdata;
        end
        if (phase == PH_BUBBLE) bubble_rdata = dmem_rdata;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_tallies();
        cnt_stall = 0; cnt_req = 0; cnt_done = 0; cnt_done_stall = 0; unstable = 0;
        first_req = 1'b1;
    endtask

    // Noise on inputs the bridge must ignore in the current phase.
    task automatic noise();
        bus_if.bus_req_ready = rnd_bit();
        bus_if.bus_rsp_valid = rnd_bit();
        bus_if.bus_rsp_rdata = rnd32();
        bus_if.bus_rsp_err   = rnd_bit();
    endtask

    // Capture cycle plus request phase of dr wait cycles before ready.
    task automatic issue(input logic [31:0] addr, input logic [3:0] wstrb,
                         input logic [31:0] wdata, input int dr);
        clear_tallies();
        t_addr = addr; t_wstrb = wstrb; t_wdata = wdata;
        dmem_valid = 1'b1; dmem_addr = addr; dmem_wstrb = wstrb; dmem_wdata = wdata;
        stall_in = rnd_bit();
        noise();
        tick(1'b1, 1'b0, PH_IDLE);
        for (int i = 0; i <= dr; i++) begin
            // The core may change its port while stalled; the bus must not see it.
            dmem_valid = quiet ? 1'b1 : rnd_bit();
            dmem_addr  = rnd32(); dmem_wstrb = 4'($urandom); dmem_wdata = rnd32();
            stall_in   = rnd_bit();
            noise();
            bus_if.bus_req_ready = (i == dr);
            tick(1'b1, 1'b1, PH_REQ);
        end
    endtask

    task automatic txn(input int gap, input int dr, input int ds, input int nh,
                       input logic [31:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic err, input logic bubble_valid);
        for (int i = 0; i < gap; i++) begin
            dmem_valid = 1'b0; dmem_addr = rnd32(); stall_in = rnd_bit();
            noise();
            tick(1'b0, 1'b0, PH_IDLE);
        end
        issue(addr, wstrb, wdata, dr);
        for (int i = 0; i <= ds; i++) begin
            stall_in = rnd_bit();
            noise();
            bus_if.bus_rsp_valid = (i == ds);
            bus_if.bus_rsp_rdata = (i == ds) ? rdata : rnd32();
            bus_if.bus_rsp_err   = (i == ds) ? err : rnd_bit();
            tick(1'b1, 1'b0, PH_WAIT);
        end
        if (err) m_err = 1'b1;
        if (wstrb == 4'b0000) m_rdata = err ? 32'h0 : rdata;
        for (int i = 0; i <= nh; i++) begin
            stall_in   = (i < nh);
            dmem_valid = rnd_bit();
            noise();
            tick(1'b0, 1'b0, PH_DONE);
        end
        dmem_valid = bubble_valid; dmem_addr = rnd32(); stall_in = rnd_bit();
        noise();
        tick(1'b0, 1'b0, PH_BUBBLE);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        quiet = 1'b1;
        reset = 1'b1; stall_in = 1'b0; dmem_valid = 1'b0;
        dmem_addr = '0; dmem_wstrb = '0; dmem_wdata = '0;
        bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0;
        bus_if.bus_rsp_rdata = '0;   bus_if.bus_rsp_err   = 1'b0;
        t_addr = '0; t_wstrb = '0; t_wdata = '0;
        m_rdata = '0; m_err = 1'b0;
        clear_tallies();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and the idle stall combination.
        check("reset bus_req_valid", {31'd0, bus_if.bus_req_valid}, 32'd0);
        check("reset bus_error", {31'd0, bus_error}, 32'd0);
        check("reset dmem_rdata", dmem_rdata, 32'd0);
        check("idle stall quiet", {31'd0, stall}, 32'd0);
        stall_in = 1'b1; #1;
        check("idle stall from stall_in", {31'd0, stall}, 32'd1);
        stall_in = 1'b0; dmem_valid = 1'b1; #1;
        check("idle stall from dmem_valid", {31'd0, stall}, 32'd1);
        dmem_valid = 1'b0;
        tick(1'b0, 1'b0, PH_IDLE);

        // Read 0x100, immediate ready, response two cycles later.
        txn(0, 0, 1, 0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
        check("read stall cycles", cnt_stall, 32'd4);
        check("read rdata in DONE", done_rdata, 32'hDEADBEEF);
        check("read rdata in BUBBLE", bubble_rdata, 32'hDEADBEEF);
        check("read bus_req_addr", req_addr_seen, 32'h100);

        // Write with ready delayed three cycles.
        txn(1, 3, 0, 0, 32'h204, 4'b1100, 32'h12340000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("write req_valid cycles", cnt_req, 32'd4);
        check("write fields stable", unstable, 32'd0);
        check("write rdata unchanged", done_rdata, 32'hDEADBEEF);

        // Back-to-back with dmem_valid held through BUBBLE.
        txn(0, 0, 0, 0, 32'h280, 4'b0000, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
        txn(0, 0, 0, 0, 32'h300, 4'b0000, 32'h0, 32'h0BADCAFE, 1'b0, 1'b0);
        check("b2b second addr", req_addr_seen, 32'h300);
        check("b2b second req cycles", cnt_req, 32'd1);
        check("b2b second rdata", done_rdata, 32'h0BADCAFE);

        // stall_in held for two DONE cycles.
        txn(0, 0, 0, 2, 32'h40, 4'b0000, 32'h0, 32'h11112222, 1'b0, 1'b0);
        check("done hold cycles", cnt_done, 32'd3);
        check("done stalled cycles", cnt_done_stall, 32'd2);

        // Randomized traffic with strays and foreign stalls.
        quiet = 1'b0;
        for (int n = 0; n < 150; n++) begin
            logic        wr;
            logic [3:0]  ws;
            wr = 1'($urandom_range(0, 1));
            ws = wr ? 4'($urandom_range(1, 15)) : 4'b0000;
            txn($urandom_range(0, 3), $urandom_range(0, DMAX), $urandom_range(0, DMAX),
                $urandom_range(0, 2), {rnd32() & 32'hFFFF_FFFC}, ws, rnd32(), rnd32(),
                ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        quiet = 1'b1;

        // Error read: data forced to zero, error sticky across a good read.
        txn(1, 0, 0, 0, 32'h500, 4'b0000, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
        check("err read rdata", done_rdata, 32'h0);
        check("err flag set", {31'd0, bus_error}, 32'd1);
        txn(1, 0, 0, 0, 32'h504, 4'b0000, 32'h0, 32'h600DF00D, 1'b0, 1'b0);
        check("err flag sticky", {31'd0, bus_error}, 32'd1);
        check("good read after err", done_rdata, 32'h600DF00D);

        // Reset while in WAIT, then a stray response that must be dropped.
        issue(32'h508, 4'b0000, 32'h0, 0);
        dmem_valid = 1'b0; noise(); reset = 1'b1;
        tick(1'b1, 1'b0, PH_WAIT);
        reset = 1'b0; m_rdata = '0; m_err = 1'b0;
        bus_if.bus_rsp_valid = 1'b1; bus_if.bus_rsp_rdata = 32'h5555AAAA; bus_if.bus_rsp_err = 1'b1;
        tick(1'b0, 1'b0, PH_IDLE);
        bus_if.bus_rsp_valid = 1'b0; bus_if.bus_rsp_err = 1'b0;
        tick(1'b0, 1'b0, PH_IDLE);
        check("stray rsp rdata", dmem_rdata, 32'h0);
        check("stray rsp error", {31'd0, bus_error}, 32'd0);
        txn(0, 1, 1, 0, 32'h600, 4'b0000, 32'h0, 32'h7777_0001, 1'b0, 1'b0);
        check("read after reset", done_rdata, 32'h7777_0001);

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
        // No ready ever: the watchdog completes after 8 outstanding cycles.
        t_addr = 32'h700; t_wstrb = 4'b0000; t_wdata = 32'h0;
        clear_tallies();
        dmem_valid = 1'b1; dmem_addr = 32'h700; dmem_wstrb = 4'b0000; stall_in = 1'b0;
        bus_if.bus_req_ready = 1'b0; bus_if.bus_rsp_valid = 1'b0;
        tick(1'b1, 1'b0, PH_IDLE);
        for (int i = 0; i < 8; i++) tick(1'b1, 1'b1, PH_REQ);
        m_err = 1'b1; m_rdata = '0;
        dmem_valid = 1'b0;
        tick(1'b0, 1'b0, PH_DONE);
        tick(1'b0, 1'b0, PH_BUBBLE);
        check("timeout req cycles", cnt_req, 32'd8);
        check("timeout rdata", done_rdata, 32'h0);
        check("timeout error", {31'd0, bus_error}, 32'd1);
`endif

        check("scoreboard drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nerv_dmem_bridge.md
NERV_DMEM_BRIDGE -- requirements
Module: nerv_dmem_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: watchdog limit in cycles, used only when the timeout feature is compiled in.
REQ-002 clock  input  1  clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall_in  input  1  stall request from other sources (e.g. the fetch side).
REQ-005 stall  output  1  stall to core; equals stall_in OR the bridge's internal stall.
REQ-006 dmem_valid  input  1  core data request, combinational from core.
REQ-007 dmem_addr  input  32  word-aligned request address.
REQ-008 dmem_wstrb  input  4  byte write strobes; 0 means read.
REQ-009 dmem_wdata  input  32  write data, already lane-shifted.
REQ-010 dmem_rdata  output  32  read data returned to core.
REQ-011 bus_req_valid  output  1  bus request valid.
REQ-012 bus_req_ready  input  1  bus request accepted.
REQ-013 bus_req_addr, bus_req_wstrb, bus_req_wdata  output  32/4/32  registered copies of the captured request.
REQ-014 bus_rsp_valid  input  1  response or write acknowledge, one cycle per request.
REQ-015 bus_rsp_rdata  input  32  response data.
REQ-016 bus_rsp_err  input  1  bus error, qualified by bus_rsp_valid.
REQ-017 bus_error  output  1  sticky error flag.

Function
REQ-018 The FSM SHALL have states IDLE, REQ, WAIT, DONE and BUBBLE.
REQ-019 IDLE: internal stall = dmem_valid; on dmem_valid, capture addr, wstrb and wdata and go to REQ, regardless of stall_in.
REQ-020 REQ: bus_req_valid = 1 and internal stall = 1; on bus_req_ready go to WAIT; the request fields SHALL stay stable until accepted.
REQ-021 WAIT: internal stall = 1; on bus_rsp_valid go to DONE.
- For a read: register bus_rsp_rdata, or 0 if bus_rsp_err.
- For a write: leave the read-data register unchanged.
REQ-022 A bus_rsp_valid arriving in the same cycle as bus_req_ready SHALL be ignored; the response is accepted only in WAIT.
REQ-023 DONE: internal stall = 0 (core commits).
- If stall_in = 0, go to BUBBLE.
- Otherwise remain in DONE.
REQ-024 BUBBLE: internal stall = 0; dmem_valid is ignored (the core reissues the instruction); go to IDLE unconditionally.
REQ-025 dmem_rdata SHALL be driven from the read-data register at all times, so it is valid in DONE and BUBBLE.
REQ-026 A bus_rsp_valid outside WAIT SHALL be dropped without state change.
REQ-027 bus_rsp_err in WAIT SHALL set bus_error, which stays set until reset.
REQ-028 Minimum latency, dmem_valid to core commit: 3 cycles (IDLE, REQ with ready, WAIT with response, commit in DONE); each ready or response wait cycle adds one.

Reset
REQ-029 On reset the block SHALL:
- enter IDLE;
- drive bus_req_valid = 0, bus_error = 0, read-data register = 0 and watchdog = 0;
- drive stall = stall_in OR (dmem_valid in IDLE).
REQ-030 Reset during REQ or WAIT SHALL abandon the transaction; a late response is dropped per REQ-026.

Configuration
REQ-031 Macro NERV_DMEM_BRIDGE_TIMEOUT_EN.
REQ-032 With the macro defined:
- a counter clears on entry to REQ and increments each cycle in REQ or WAIT;
- on reaching TIMEOUT_CYCLES, go to DONE with bus_error set and read data 0;
- bus_req_valid SHALL drop on that transition.
REQ-033 Without the macro: no counter exists, and REQ/WAIT wait indefinitely.

Structure
REQ-034 Package nerv_dmem_pkg SHALL hold the FSM state enum and the default TIMEOUT_CYCLES constant.
REQ-035 The watchdog SHALL be sub-module nerv_dmem_watchdog (clear, count_en, expired), instantiated only under NERV_DMEM_BRIDGE_TIMEOUT_EN.

Verification
REQ-036 Read at addr 0x100, ready immediate, response 2 cycles later with 0xDEADBEEF:
- stall high 4 cycles;
- dmem_rdata = 0xDEADBEEF in DONE and BUBBLE;
- bus_req_addr = 0x100.
REQ-037 Write addr 0x204, wstrb 4'b1100, wdata 0x12340000, ready delayed 3 cycles:
- bus_req_valid held 4 cycles with stable fields;
- ack ends the stall;
- dmem_rdata unchanged.
REQ-038 Back-to-back requests with dmem_valid held high through BUBBLE: no bus request in BUBBLE; the next request is captured in the following IDLE.
REQ-039 stall_in = 1 during DONE for 2 cycles: the FSM stays in DONE, stall stays high, then it proceeds to BUBBLE.
REQ-040 Read with bus_rsp_err = 1: dmem_rdata = 0 and bus_error = 1, persisting until reset.
- Reset asserted in WAIT: IDLE next cycle.
- The subsequent stray bus_rsp_valid is ignored.
REQ-041 With TIMEOUT_CYCLES = 8 under the macro and no response: DONE after 8 cycles in REQ/WAIT, with bus_error = 1 and dmem_rdata = 0.
